// File: rtl/unit_output_collector.sv
// unit_output_collector: round-robin UOB poller that reassembles narrow packet streams into a FWFT FIFO.
// Each packet enters the FIFO as a unit-ID word followed by PKT_LEN assembled words.
module unit_output_collector #(
    parameter int N_UNITS     = 4,
    parameter int IN_WIDTH    = 2,
    parameter int OUT_WIDTH   = 16,
    parameter int PKT_LEN     = 36,
    parameter int FIFO_MSB    = 6,
    parameter int HDR_TIMEOUT = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_UNITS*IN_WIDTH-1:0]   unit_dout,
    input  logic [N_UNITS-1:0]            unit_empty,
    output logic [N_UNITS-1:0]            unit_rd_en,
    output logic [OUT_WIDTH-1:0]          dout,
    output logic                          empty,
    input  logic                          rd_en,
    output logic                          err
);
    localparam int RATIO       = OUT_WIDTH / IN_WIDTH;
    localparam int OUT_N_WORDS = PKT_LEN * RATIO;
    localparam int UW          = N_UNITS > 1 ? $clog2(N_UNITS) : 1;
    localparam int AW          = FIFO_MSB + 1;
    localparam int CW          = FIFO_MSB + 2;
    localparam int DEPTH       = 2 ** AW;
    localparam int NW          = $clog2(OUT_N_WORDS + 1);
    localparam int TW          = $clog2(HDR_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT_HDR, COLLECT, GAP} state_t;

    state_t                 state_q, state_d;
    logic [UW-1:0]          sel_q, sel_d, rr_q, rr_d, sel_nxt, pick;
    logic [N_UNITS-1:0]     grant_q, grant_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [NW-1:0]          cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0]   asm_q, asm_d, wr_data, dout_q;
    logic [IN_WIDTH-1:0]    in_q;
    logic                   err_q, err_d, found, wr, pop, avail, space_ok, empty_q;
    logic [AW-1:0]          wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          fcnt_q;
    logic [OUT_WIDTH-1:0]   mem [DEPTH];

    assign unit_rd_en = grant_q;
    assign dout       = dout_q;
    assign empty      = empty_q;
    assign err        = err_q;
    assign sel_nxt    = (sel_q == UW'(N_UNITS - 1)) ? '0 : sel_q + 1'b1;
    // Space is checked before granting because the UOB cannot be stalled once started.
    assign space_ok   = (CW'(DEPTH) - fcnt_q) >= CW'(PKT_LEN + 1);
    assign pop        = rd_en && !empty_q;
    assign rd_ptr_d   = rd_ptr_q + AW'(pop);
    assign avail      = (fcnt_q - CW'(pop)) != '0;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < N_UNITS; k++) begin
            if (!found && !unit_empty[(int'(rr_q) + k) % N_UNITS]) begin
                found = 1'b1;
                pick  = UW'((int'(rr_q) + k) % N_UNITS);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        rr_d    = rr_q;
        grant_d = '0;
        timer_d = timer_q;
        cnt_d   = cnt_q;
        asm_d   = asm_q;
        err_d   = err_q;
        wr      = 1'b0;
        wr_data = '0;
        case (state_q)
            IDLE: if (space_ok && found) begin
                grant_d = N_UNITS'(1) << pick;
                sel_d   = pick;
                timer_d = '0;
                state_d = WAIT_HDR;
            end
            WAIT_HDR: if (in_q == '1) begin
                wr      = 1'b1;
                wr_data = OUT_WIDTH'(sel_q);
                cnt_d   = '0;
                state_d = COLLECT;
            end else if (timer_q == TW'(HDR_TIMEOUT)) begin
                err_d   = 1'b1;
                rr_d    = sel_nxt;
                state_d = IDLE;
            end else begin
                timer_d = timer_q + 1'b1;
            end
            COLLECT: begin
                asm_d   = (asm_q >> IN_WIDTH) | (OUT_WIDTH'(in_q) << (OUT_WIDTH - IN_WIDTH));
                wr      = (int'(cnt_q) % RATIO) == RATIO - 1;
                wr_data = asm_d;
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == NW'(OUT_N_WORDS - 1)) ? GAP : COLLECT;
            end
            GAP: begin
                rr_d    = sel_nxt;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            rr_q     <= '0;
            grant_q  <= '0;
            timer_q  <= '0;
            cnt_q    <= '0;
            asm_q    <= '0;
            in_q     <= '0;
            err_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fcnt_q   <= '0;
            dout_q   <= '0;
            empty_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rr_q     <= rr_d;
            grant_q  <= grant_d;
            timer_q  <= timer_d;
            cnt_q    <= cnt_d;
            asm_q    <= asm_d;
            in_q     <= unit_dout[int'(sel_q)*IN_WIDTH +: IN_WIDTH];
            err_q    <= err_d;
            wr_ptr_q <= wr_ptr_q + AW'(wr);
            rd_ptr_q <= rd_ptr_d;
            fcnt_q   <= fcnt_q + CW'(wr) - CW'(pop);
            // Head register ignores this cycle's write, giving the two-cycle write-to-visible latency.
            dout_q   <= avail ? mem[rd_ptr_d] : dout_q;
            empty_q  <= !avail;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr_q] <= wr_data;
    end
endmodule
